// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the transaction-layer FIFO controller.
//   FIFO_ADDR_W : default memory address width (16 entries)
//   FIFO_PTR_W  : pointer width, one extra wrap bit above the address
//   FIFO_DEPTH  : number of array entries
//   state_t     : pause flow-control FSM encoding
package fifo_ctrl_pkg;

    localparam int FIFO_ADDR_W = 4;
    localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;
    localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// PTR_W-bit wrap counter used for the FIFO write and read pointers.
// The MSB acts as the wrap bit; the counter rolls over modulo 2**PTR_W.
// Ports:
//   clk     : rising-edge clock
//   reset_L : asynchronous active-low reset, clears the pointer
//   en      : advance the pointer by one this cycle
//   ptr     : registered pointer value
module fifo_ptr_cnt
    import fifo_ctrl_pkg::*;
#(
    parameter int PTR_W = FIFO_PTR_W
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, flag and flow-control controller for a 2**ADDR_W-entry FIFO array.
// Drives the array write enable and write/read pointers, tracks occupancy,
// and produces full/empty, almost flags, sticky errors and a hysteretic
// pause request for the upstream sender.
// Ports:
//   clk, reset_L           : clock and asynchronous active-low reset
//   push, pop              : write / read requests
//   af_thresh, ae_thresh   : almost-full (pause-on) / almost-empty (resume) levels
//   err_clr                : clears the sticky error flags
//   fifo_we                : array write enable (combinational)
//   wptr, rptr             : registered array pointers, MSB is the wrap bit
//   count                  : registered occupancy 0..DEPTH
//   full, empty            : pointer-derived status
//   almost_full/_empty     : occupancy compared against the live thresholds
//   pause                  : registered flow-control stop
//   overflow_err           : sticky, a push was dropped while full
//   underflow_err          : sticky, a pop was dropped while empty
//   cfg_err                : thresholds inconsistent (ae_thresh >= af_thresh)
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int PTR_W  = ADDR_W + 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic             pop,
    input  logic [PTR_W-1:0] af_thresh,
    input  logic [PTR_W-1:0] ae_thresh,
    input  logic             err_clr,
    output logic             fifo_we,
    output logic [PTR_W-1:0] wptr,
    output logic [PTR_W-1:0] rptr,
    output logic [PTR_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             pause,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic             cfg_err
);

    logic             push_ok;
    logic             pop_ok;
    logic [PTR_W-1:0] count_q;
    logic [PTR_W-1:0] count_next;
    logic             ovf_q;
    logic             unf_q;
    state_t           state_q;
    state_t           state_d;

    // Status from pointers: same slot with differing wrap bits means full.
    assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign empty = (wptr == rptr);

    // A push while full is still accepted when a pop frees the slot in the
    // same cycle; a pop while empty is always rejected, even with a push.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign fifo_we = push_ok;

    assign count_next = count_q + PTR_W'(push_ok) - PTR_W'(pop_ok);

    assign count        = count_q;
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign cfg_err      = (ae_thresh >= af_thresh);

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
    assign pause         = (state_q == ST_PAUSE);

    fifo_ptr_cnt #(.PTR_W(PTR_W)) u_wptr (
        .clk     (clk),
        .reset_L (reset_L),
        .en      (push_ok),
        .ptr     (wptr)
    );

    fifo_ptr_cnt #(.PTR_W(PTR_W)) u_rptr (
        .clk     (clk),
        .reset_L (reset_L),
        .en      (pop_ok),
        .ptr     (rptr)
    );

    // Occupancy and sticky errors; a new error event beats a clear.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_next;
            if (push && !push_ok) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (pop && !pop_ok) begin
                unf_q <= 1'b1;
            end else if (err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    // Pause FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Hysteresis on the post-update occupancy so pause changes on the same
    // edge that count crosses a threshold. Inconsistent thresholds force RUN.
    always_comb begin
        state_d = state_q;
        if (cfg_err) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   if (count_next >= af_thresh) state_d = ST_PAUSE;
                ST_PAUSE: if (count_next <= ae_thresh) state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
    import fifo_ctrl_pkg::*;

    localparam int PW = FIFO_PTR_W;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          err_clr = 1'b0;
    logic [PW-1:0] af_thresh = 5'd3;
    logic [PW-1:0] ae_thresh = 5'd1;
    logic          fifo_we, full, empty, almost_full, almost_empty;
    logic          pause, overflow_err, underflow_err, cfg_err;
    logic [PW-1:0] wptr, rptr, count;

    fifo_ctrl dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .push          (push),
        .pop           (pop),
        .af_thresh     (af_thresh),
        .ae_thresh     (ae_thresh),
        .err_clr       (err_clr),
        .fifo_we       (fifo_we),
        .wptr          (wptr),
        .rptr          (rptr),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .pause         (pause),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the 16x10 array, written through the DUT's enable/pointer.
    logic [9:0] mem [16];
    logic [9:0] wdata = '0;
    always @(posedge clk) if (fifo_we) mem[wptr[3:0]] <= wdata;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_w, m_r, m_cnt;
    bit m_pause, m_ovf, m_unf;
    logic [9:0] sb [$];

    typedef struct {
        bit push; bit pop; bit clr;
        bit we; int cnt; bit pause; bit ovf; bit unf;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_r = 0; m_cnt = 0;
        m_pause = 0; m_ovf = 0; m_unf = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_L = 1'b0;
        #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        #1;
        chk("rst_wptr", int'(wptr), 0);
        chk("rst_rptr", int'(rptr), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_pause", int'(pause), 0);
        chk("rst_ovf", int'(overflow_err), 0);
        chk("rst_unf", int'(underflow_err), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_we", int'(fifo_we), 0);
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic step(input bit p, input bit q, input bit c, output bit we_seen);
        bit pok, qok;
        int af, ae;
        @(negedge clk);
        push = p; pop = q; err_clr = c;
        wdata = 10'($urandom);
        af = int'(af_thresh);
        ae = int'(ae_thresh);
        pok = p && (m_cnt < 16 || q);
        qok = q && (m_cnt > 0);
        #1;
        we_seen = fifo_we;
        chk("fifo_we", int'(fifo_we), int'(pok));
        if (qok) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_underrun: got pop with no expected data, required queued entry");
            end else begin
                chk("rdata", int'(mem[rptr[3:0]]), int'(sb.pop_front()));
            end
        end
        if (pok) sb.push_back(wdata);
        if (p && !pok) m_ovf = 1; else if (c) m_ovf = 0;
        if (q && !qok) m_unf = 1; else if (c) m_unf = 0;
        m_w = (m_w + int'(pok)) % 32;
        m_r = (m_r + int'(qok)) % 32;
        m_cnt = m_cnt + int'(pok) - int'(qok);
        if (ae >= af) m_pause = 0;
        else if (!m_pause && m_cnt >= af) m_pause = 1;
        else if (m_pause && m_cnt <= ae) m_pause = 0;
        @(posedge clk);
        #1;
        chk("wptr", int'(wptr), m_w);
        chk("rptr", int'(rptr), m_r);
        chk("count", int'(count), m_cnt);
        chk("pause", int'(pause), int'(m_pause));
        chk("ovf", int'(overflow_err), int'(m_ovf));
        chk("unf", int'(underflow_err), int'(m_unf));
        chk("full", int'(full), int'(m_cnt == 16));
        chk("empty", int'(empty), int'(m_cnt == 0));
        chk("almost_full", int'(almost_full), int'(m_cnt >= af));
        chk("almost_empty", int'(almost_empty), int'(m_cnt <= ae));
        chk("cfg_err", int'(cfg_err), int'(ae >= af));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit we;
        logic [PW-1:0] w0, r0;

        // push pop clr | we cnt pause ovf unf   (af=3, ae=1)
        tbl[0]  = '{1,0,0, 1,1,0,0,0};
        tbl[1]  = '{1,0,0, 1,2,0,0,0};
        tbl[2]  = '{1,0,0, 1,3,1,0,0};
        tbl[3]  = '{1,1,0, 1,3,1,0,0};
        tbl[4]  = '{0,1,0, 0,2,1,0,0};
        tbl[5]  = '{0,1,0, 0,1,0,0,0};
        tbl[6]  = '{0,1,0, 0,0,0,0,0};
        tbl[7]  = '{0,1,0, 0,0,0,0,1};
        tbl[8]  = '{1,1,0, 1,1,0,0,1};
        tbl[9]  = '{0,0,1, 0,1,0,0,0};
        tbl[10] = '{0,0,0, 0,1,0,0,0};
        tbl[11] = '{0,1,0, 0,0,0,0,0};

        af_thresh = 5'd3; ae_thresh = 5'd1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].clr, we);
            chk($sformatf("tbl%0d_we", i), int'(we), int'(tbl[i].we));
            chk($sformatf("tbl%0d_cnt", i), int'(count), tbl[i].cnt);
            chk($sformatf("tbl%0d_pause", i), int'(pause), int'(tbl[i].pause));
            chk($sformatf("tbl%0d_ovf", i), int'(overflow_err), int'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf", i), int'(underflow_err), int'(tbl[i].unf));
        end

        // Fill to full with hysteresis thresholds
        af_thresh = 5'd12; ae_thresh = 5'd4;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, we);
            if (i == 10) chk("fill_pause_at11", int'(pause), 0);
            if (i == 11) chk("fill_pause_at12", int'(pause), 1);
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 16);
        chk("fill_wptr", int'(wptr), 16);
        step(1, 0, 0, we);
        chk("ovf_we", int'(we), 0);
        chk("ovf_set", int'(overflow_err), 1);

        // Drain with hysteresis
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, we);
            if (i == 10) chk("drain_pause_at5", int'(pause), 1);
            if (i == 11) chk("drain_pause_at4", int'(pause), 0);
        end
        chk("drain_empty", int'(empty), 1);
        step(0, 1, 0, we);
        chk("unf_set", int'(underflow_err), 1);
        chk("unf_rptr_held", int'(rptr), 16);
        step(0, 0, 1, we);
        chk("clr_ovf", int'(overflow_err), 0);
        chk("clr_unf", int'(underflow_err), 0);

        // Push and pop together at full
        for (int i = 0; i < 16; i++) step(1, 0, 0, we);
        w0 = wptr; r0 = rptr;
        step(1, 1, 0, we);
        chk("fullpp_count", int'(count), 16);
        chk("fullpp_wptr", int'(wptr), (int'(w0) + 1) % 32);
        chk("fullpp_rptr", int'(rptr), (int'(r0) + 1) % 32);
        chk("fullpp_slot", int'(mem[r0[3:0]]), int'(wdata));

        // Push and pop together at empty
        for (int i = 0; i < 16; i++) step(0, 1, 0, we);
        r0 = rptr; w0 = wptr;
        step(1, 1, 0, we);
        chk("emptypp_count", int'(count), 1);
        chk("emptypp_wptr", int'(wptr), (int'(w0) + 1) % 32);
        chk("emptypp_rptr", int'(rptr), int'(r0));
        chk("emptypp_unf", int'(underflow_err), 1);
        step(0, 0, 1, we);
        chk("emptypp_clr", int'(underflow_err), 0);
        step(0, 1, 0, we);

        // Pointer wrap
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, we);
            step(0, 1, 0, we);
        end

        // Configuration error forces RUN
        af_thresh = 5'd8; ae_thresh = 5'd8;
        for (int i = 0; i < 16; i++) step(1, 0, 0, we);
        chk("cfg_err_set", int'(cfg_err), 1);
        chk("cfg_pause_low", int'(pause), 0);
        chk("cfg_count", int'(count), 16);

        // Reset in the middle of traffic
        af_thresh = 5'd12; ae_thresh = 5'd4;
        step(0, 1, 0, we);
        step(1, 1, 0, we);
        do_reset();
        step(1, 0, 0, we);
        chk("post_rst_wptr", int'(wptr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
